// File: rtl/bram_clear_engine_if.sv
// ---------------------------------------------------------------------------
// bram_clear_engine_if
// Host access bus of bram_clear_engine.
//   i_request  host access request, held until o_ready
//   i_rw       1 = write, 0 = read
//   i_address  byte address
//   i_wdata    write data
//   i_wstrb    byte write enables
//   o_rdata    read data, valid while o_ready is high
//   o_ready    access complete, one-cycle pulse
// Modports: master (host side), slave (memory side).
// ---------------------------------------------------------------------------
interface bram_clear_engine_if #(
    parameter int unsigned WIDTH = 32
);
    logic                 i_request;
    logic                 i_rw;
    logic [31:0]          i_address;
    logic [WIDTH-1:0]     i_wdata;
    logic [WIDTH/8-1:0]   i_wstrb;
    logic [WIDTH-1:0]     o_rdata;
    logic                 o_ready;

    modport master (
        output i_request, i_rw, i_address, i_wdata, i_wstrb,
        input  o_rdata, o_ready
    );

    modport slave (
        input  i_request, i_rw, i_address, i_wdata, i_wstrb,
        output o_rdata, o_ready
    );
endinterface

// File: rtl/bram_clear_engine.sv
// ---------------------------------------------------------------------------
// bram_clear_engine
// Single-port block RAM with a built-in clear engine. After reset the whole
// array is filled with RESET_VALUE; at runtime a word range can be filled with
// an arbitrary value on command. Host accesses are stalled while clearing.
//
// Ports:
//   i_clock, i_reset   clock, synchronous active-high reset
//   o_initialized      high once the post-reset clear has completed
//   o_busy             clear engine running
//   bus                host access bus (bram_clear_engine_if.slave)
//   i_clear            start runtime clear (sampled only when idle)
//   i_clear_base       first word index of clear range
//   i_clear_count      number of words to clear
//   i_clear_value      value written by runtime clear
//   o_clear_done       one-cycle pulse when runtime clear finishes
//
// Build option: BRAM_CLEAR_INSTANT_EN makes both clears complete in a single
// cycle (simulation only). Undefined by default: one word per cycle.
// ---------------------------------------------------------------------------
module bram_clear_engine #(
    parameter int unsigned      WIDTH       = 32,
    parameter int unsigned      SIZE        = 32'h400,
    parameter int unsigned      ADDR_LSH    = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic               i_clock,
    input  logic               i_reset,
    output logic               o_initialized,
    output logic               o_busy,
    bram_clear_engine_if.slave bus,
    input  logic               i_clear,
    input  logic [31:0]        i_clear_base,
    input  logic [31:0]        i_clear_count,
    input  logic [WIDTH-1:0]   i_clear_value,
    output logic               o_clear_done
);
    localparam int unsigned AW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int unsigned NB = WIDTH / 8;

    typedef enum logic [1:0] {C_INIT, C_IDLE, C_RUN}  clr_state_t;
    typedef enum logic [1:0] {H_IDLE, H_ACK, H_HOLD} host_state_t;

    logic [WIDTH-1:0] mem [SIZE];

    clr_state_t       clr_state_q, clr_state_d;
    host_state_t      host_state_q, host_state_d;
    logic [31:0]      ptr_q, ptr_d;
    logic [31:0]      rem_q, rem_d;
    logic [WIDTH-1:0] val_q, val_d;
    logic             init_q, init_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] rdata_q;

    logic             clr_we;
    logic [WIDTH-1:0] clr_wval;
    logic             init_all;
    logic             range_all;
    logic             accept;
    logic             host_wr;
    logic             host_rd;
    logic [AW-1:0]    host_idx;
    logic             unused_addr;

    // Upper address bits fold away through the truncating cast.
    assign host_idx    = AW'(bus.i_address >> ADDR_LSH);
    assign unused_addr = ^bus.i_address;

    // ---------------- clear FSM ----------------
    always_comb begin
        clr_state_d = clr_state_q;
        ptr_d       = ptr_q;
        rem_d       = rem_q;
        val_d       = val_q;
        init_d      = init_q;
        done_d      = 1'b0;
        clr_we      = 1'b0;
        clr_wval    = val_q;
        init_all    = 1'b0;
        range_all   = 1'b0;
        case (clr_state_q)
            C_INIT: begin
`ifdef BRAM_CLEAR_INSTANT_EN
                init_all    = 1'b1;
                clr_state_d = C_IDLE;
                init_d      = 1'b1;
`else
                clr_we   = 1'b1;
                clr_wval = RESET_VALUE;
                ptr_d    = ptr_q + 32'd1;
                if (ptr_q == 32'(SIZE - 1)) begin
                    clr_state_d = C_IDLE;
                    init_d      = 1'b1;
                end
`endif
            end
            C_IDLE: begin
                if (i_clear) begin
`ifdef BRAM_CLEAR_INSTANT_EN
                    range_all = 1'b1;
                    done_d    = 1'b1;
`else
                    if (i_clear_count == 32'd0) begin
                        done_d = 1'b1;
                    end else begin
                        clr_state_d = C_RUN;
                        ptr_d       = i_clear_base;
                        rem_d       = i_clear_count;
                        val_d       = i_clear_value;
                    end
`endif
                end
            end
            C_RUN: begin
                clr_we = 1'b1;
                ptr_d  = ptr_q + 32'd1;
                rem_d  = rem_q - 32'd1;
                if (rem_q == 32'd1) begin
                    clr_state_d = C_IDLE;
                    done_d      = 1'b1;
                end
            end
            default: clr_state_d = C_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            clr_state_q <= C_INIT;
            ptr_q       <= '0;
            rem_q       <= '0;
            val_q       <= '0;
            init_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            clr_state_q <= clr_state_d;
            ptr_q       <= ptr_d;
            rem_q       <= rem_d;
            val_q       <= val_d;
            init_q      <= init_d;
            done_q      <= done_d;
        end
    end

    // ---------------- host FSM ----------------
    // A pending i_clear takes priority over a host request in the same cycle.
    always_comb begin
        accept       = (host_state_q == H_IDLE) && bus.i_request &&
                       (clr_state_q == C_IDLE) && !i_clear;
        host_wr      = accept && bus.i_rw;
        host_rd      = accept && !bus.i_rw;
        host_state_d = host_state_q;
        case (host_state_q)
            H_IDLE:  if (accept) host_state_d = H_ACK;
            H_ACK:   host_state_d = bus.i_request ? H_HOLD : H_IDLE;
            H_HOLD:  if (!bus.i_request) host_state_d = H_IDLE;
            default: host_state_d = H_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            host_state_q <= H_IDLE;
            rdata_q      <= '0;
        end else begin
            host_state_q <= host_state_d;
            if (host_rd) rdata_q <= mem[host_idx];
        end
    end

    // ---------------- memory array ----------------
    // Clear writes and host writes never coincide: accept requires the clear
    // engine idle with no clear being started.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
`ifdef BRAM_CLEAR_INSTANT_EN
            if (init_all) begin
                for (int unsigned i = 0; i < SIZE; i++) mem[AW'(i)] <= RESET_VALUE;
            end else if (range_all) begin
                // Writing at most SIZE words covers any wrapped rewrite.
                for (int unsigned n = 0; n < SIZE; n++)
                    if (32'(n) < i_clear_count)
                        mem[AW'(i_clear_base + 32'(n))] <= i_clear_value;
            end else
`endif
            if (clr_we) begin
                mem[AW'(ptr_q)] <= clr_wval;
            end else if (host_wr) begin
                for (int unsigned b = 0; b < NB; b++)
                    if (bus.i_wstrb[b]) mem[host_idx][b*8 +: 8] <= bus.i_wdata[b*8 +: 8];
            end
        end
    end

    assign o_busy        = (clr_state_q != C_IDLE);
    assign o_initialized = init_q;
    assign o_clear_done  = done_q;
    assign bus.o_ready   = (host_state_q == H_ACK);
    assign bus.o_rdata   = rdata_q;

endmodule

// File: tb/tb_bram_clear_engine.sv
// ---------------------------------------------------------------------------
// tb_bram_clear_engine
// Self-checking bench for bram_clear_engine (SIZE=16, WIDTH=32) against an
// array reference model. Inputs are driven and outputs sampled on the
// falling clock edge.
// ---------------------------------------------------------------------------
module tb_bram_clear_engine;
    localparam int unsigned SZ = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        init;
    logic        busy;
    logic        clr;
    logic [31:0] cbase;
    logic [31:0] ccount;
    logic [31:0] cval;
    logic        done;

    always #5 clk = ~clk;

    bram_clear_engine_if #(.WIDTH(32)) bus ();

    bram_clear_engine #(
        .WIDTH      (32),
        .SIZE       (SZ),
        .ADDR_LSH   (2),
        .RESET_VALUE(32'h0)
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .o_initialized(init),
        .o_busy       (busy),
        .bus          (bus),
        .i_clear      (clr),
        .i_clear_base (cbase),
        .i_clear_count(ccount),
        .i_clear_value(cval),
        .o_clear_done (done)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          done_cnt = 0;
    logic [31:0] model [SZ];

    // Counts every cycle that o_clear_done is high.
    always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_clear(input logic [31:0] base, input logic [31:0] count, input logic [31:0] value);
        for (longint n = 0; n < longint'(count); n++)
            model[(longint'(base) + n) % SZ] = value;
    endtask

    task automatic access(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, output logic [31:0] rd);
        int lat = 0;
        int idx;
        bus.i_request = 1'b1;
        bus.i_rw      = rw;
        bus.i_address = addr;
        bus.i_wdata   = wdata;
        bus.i_wstrb   = strb;
        do begin
            @(negedge clk);
            lat++;
        end while (bus.o_ready !== 1'b1 && lat < 100);
        rd = bus.o_rdata;
        check("acc_latency", lat, 1);
        bus.i_request = 1'b0;
        @(negedge clk);
        check("acc_ready_pulse", {31'b0, bus.o_ready}, 32'd0);
        if (rw) begin
            idx = int'((addr / 4) % SZ);
            for (int b = 0; b < 4; b++)
                if (strb[b]) model[idx][b*8 +: 8] = wdata[b*8 +: 8];
        end
    endtask

    task automatic read_all(input string tag);
        logic [31:0] rd;
        logic [31:0] addr;
        for (int i = 0; i < SZ; i++) begin
            addr = ($urandom & ~32'h3C) | (32'(i) << 2);
            access(1'b0, addr, 32'h0, 4'h0, rd);
            check($sformatf("%s_w%0d", tag, i), rd, model[i]);
        end
    endtask

    task automatic do_clear(input logic [31:0] base, input logic [31:0] count, input logic [31:0] value);
        int busy_n = 0;
        int dones  = 0;
        clr = 1'b1; cbase = base; ccount = count; cval = value;
        @(negedge clk);
        clr = 1'b0;
        while (busy === 1'b1 && busy_n < int'(count) + 4) begin
            busy_n++;
            if (done === 1'b1) dones++;
            @(negedge clk);
        end
        if (done === 1'b1) dones++;
        @(negedge clk);
        if (done === 1'b1) dones++;
        check("clr_busy_cycles", busy_n, count);
        check("clr_done_pulses", dones, 1);
        model_clear(base, count, value);
    endtask

    task automatic do_reset();
        int cyc = 0;
        rst = 1'b1; clr = 1'b0; bus.i_request = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_initialized", {31'b0, init}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd1);
        check("rst_ready", {31'b0, bus.o_ready}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_rdata", bus.o_rdata, 32'h0);
        rst = 1'b0;
        do begin
            @(negedge clk);
            cyc++;
        end while (init !== 1'b1 && cyc < 100);
        check("init_cycles", cyc, SZ);
        check("init_busy", {31'b0, busy}, 32'd0);
        for (int i = 0; i < SZ; i++) model[i] = 32'h0;
    endtask

    initial begin
        logic [31:0] rd;
        int          cyc, bf, rc, bad, extra, d0, op;
        logic [31:0] a, w, c;

        rst = 1'b1; clr = 1'b0; cbase = '0; ccount = '0; cval = '0;
        bus.i_request = 1'b0; bus.i_rw = 1'b0; bus.i_address = '0;
        bus.i_wdata = '0; bus.i_wstrb = '0;
        @(negedge clk);

        // Post-reset clear timing and contents.
        do_reset();
        read_all("init");

        // Byte-strobe merge.
        access(1'b1, 32'h8, 32'hDEADBEEF, 4'b1111, rd);
        access(1'b1, 32'h8, 32'h00005500, 4'b0010, rd);
        access(1'b0, 32'h8, 32'h0, 4'h0, rd);
        check("strb_merge", rd, 32'hDEAD55EF);

        // Wrapped range clear over a full memory.
        for (int i = 0; i < SZ; i++) access(1'b1, 32'(i) << 2, 32'hFFFFFFFF, 4'hF, rd);
        do_clear(32'd14, 32'd4, 32'hA5A5A5A5);
        read_all("wrap");

        // Request held across a runtime clear; clear wins the shared cycle.
        clr = 1'b1; cbase = 32'd5; ccount = 32'd3; cval = 32'h13579BDF;
        bus.i_request = 1'b1; bus.i_rw = 1'b0; bus.i_address = 32'd5 << 2;
        @(negedge clk);
        clr = 1'b0;
        cyc = 0; bf = -1; rc = -1; bad = 0;
        while (rc < 0 && cyc < 50) begin
            if (busy === 1'b1 && bus.o_ready === 1'b1) bad++;
            if (busy === 1'b0 && bf < 0) bf = cyc;
            if (bus.o_ready === 1'b1) rc = cyc;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        model_clear(32'd5, 32'd3, 32'h13579BDF);
        check("stall_busy_fall", bf, 3);
        check("stall_ready_after_busy", rc, bf + 1);
        check("stall_no_ready_busy", bad, 0);
        check("stall_rdata", bus.o_rdata, model[5]);
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.o_ready === 1'b1) extra++;
        end
        check("hold_no_repeat", extra, 0);
        bus.i_request = 1'b0;
        @(negedge clk);
        access(1'b0, 32'd6 << 2, 32'h0, 4'h0, rd);
        check("hold_reissue", rd, model[6]);

        // Zero-length clear.
        do_clear(32'd7, 32'd0, 32'h0BADF00D);
        read_all("zero");

        // Clear request while busy is ignored.
        d0 = done_cnt;
        clr = 1'b1; cbase = 32'd9; ccount = 32'd5; cval = 32'h11112222;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        clr = 1'b1; cbase = 32'd0; ccount = 32'd16; cval = 32'h33334444;
        @(negedge clk);
        clr = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        repeat (3) @(negedge clk);
        check("busy_clear_done_pulses", done_cnt - d0, 1);
        check("busy_clear_idle", {31'b0, busy}, 32'd0);
        model_clear(32'd9, 32'd5, 32'h11112222);
        read_all("ignored");

        // Reset in the middle of a runtime clear.
        d0 = done_cnt;
        clr = 1'b1; cbase = 32'd3; ccount = 32'd10; cval = 32'h77777777;
        @(negedge clk);
        clr = 1'b0;
        repeat (3) @(negedge clk);
        do_reset();
        repeat (3) @(negedge clk);
        check("midrst_no_done", done_cnt - d0, 0);
        read_all("midrst");

        // Randomized mix against the model.
        for (int it = 0; it < 150; it++) begin
            op = $urandom_range(0, 9);
            a  = $urandom;
            w  = $urandom;
            if (op < 5) begin
                access(1'b1, a, w, 4'($urandom_range(0, 15)), rd);
            end else if (op < 8) begin
                access(1'b0, a, 32'h0, 4'h0, rd);
                check("rand_read", rd, model[(a / 4) % SZ]);
            end else begin
                c = 32'($urandom_range(0, 40));
                do_clear(a, c, w);
            end
        end
        read_all("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
